keypad_scanner: RTL



---
 rtl/keypad_scanner_if.sv | 12 +
 rtl/keypad_scanner.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/keypad_scanner_if.sv
// Keypad matrix lines and debounced key outputs for one keypad_scanner instance.
// master = scanner side, slave = keypad/consumer side.
interface keypad_scanner_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] keys;
  logic       key_valid;
  logic       key_strobe;

  modport master (input row_in, output col_out, keys, key_valid, key_strobe);
  modport slave  (output row_in, input col_out, keys, key_valid, key_strobe);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with chord rejection and scan-based debounce.
// Optional auto-repeat strobes are enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner #(
  parameter int SCAN_DIV       = 25000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 50
) (
  input  logic             CLOCK_25,
  input  logic             reset,
  keypad_scanner_if.master kp
);
  localparam int DIV_W = ($clog2(SCAN_DIV) < 2) ? 2 : $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0] DEB_MAX  = 4'(DEBOUNCE_SCANS);
  localparam logic [7:0] RPT_LAST = 8'(REPEAT_SCANS - 1);
`ifdef KEYPAD_REPEAT_EN
  localparam bit REPEAT_EN = 1'b1;
`else
  localparam bit REPEAT_EN = 1'b0;
`endif

  function automatic logic [3:0] legend(input logic [3:0] idx);
    case (idx)
      4'd0:  legend = 4'h1;  4'd1:  legend = 4'h2;  4'd2:  legend = 4'h3;  4'd3:  legend = 4'hA;
      4'd4:  legend = 4'h4;  4'd5:  legend = 4'h5;  4'd6:  legend = 4'h6;  4'd7:  legend = 4'hB;
      4'd8:  legend = 4'h7;  4'd9:  legend = 4'h8;  4'd10: legend = 4'h9;  4'd11: legend = 4'hC;
      4'd12: legend = 4'hE;  4'd13: legend = 4'h0;  4'd14: legend = 4'hF;  default: legend = 4'hD;
    endcase
  endfunction

  logic [3:0]       row_meta_q, row_meta_d, row_sync_q, row_sync_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_q, col_d;
  logic [15:0]      snap_q, snap_d;
  logic             scan_done_q, scan_done_d;
  logic             stored_valid_q, stored_valid_d;
  logic [3:0]       stored_code_q, stored_code_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             commit_q, commit_d;
  logic [3:0]       keys_q, keys_d;
  logic             key_valid_q, key_valid_d;
  logic             key_strobe_q, key_strobe_d;
  logic [7:0]       rpt_q, rpt_d;

  logic [3:0] hit_idx;
  logic       cand_valid;
  logic [3:0] cand_code;
  logic       same_cand;

  // Candidate from the completed snapshot: exactly one pressed bit is a key, anything else is NONE.
  always_comb begin
    hit_idx = 4'd0;
    for (logic [4:0] i = 5'd0; i < 5'd16; i++) begin
      if (snap_q[i[3:0]]) hit_idx = i[3:0];
    end
    cand_valid = ($countones(snap_q) == 1);
    cand_code  = cand_valid ? legend(hit_idx) : 4'd0;
    same_cand  = (cand_valid == stored_valid_q) && (cand_code == stored_code_q);
  end

  always_comb begin
    row_meta_d     = kp.row_in;
    row_sync_d     = row_meta_q;
    div_d          = div_q;
    col_d          = col_q;
    snap_d         = snap_q;
    scan_done_d    = 1'b0;
    stored_valid_d = stored_valid_q;
    stored_code_d  = stored_code_q;
    cnt_d          = cnt_q;
    commit_d       = 1'b0;
    keys_d         = keys_q;
    key_valid_d    = key_valid_q;
    key_strobe_d   = 1'b0;
    rpt_d          = rpt_q;

    if (div_q == DIV_LAST) begin
      div_d                  = '0;
      col_d                  = col_q + 2'd1;
      snap_d[{2'd0, col_q}]  = ~row_sync_q[0];
      snap_d[{2'd1, col_q}]  = ~row_sync_q[1];
      snap_d[{2'd2, col_q}]  = ~row_sync_q[2];
      snap_d[{2'd3, col_q}]  = ~row_sync_q[3];
      scan_done_d            = (col_q == 2'd3);
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    // A commit is requested only on the scan where the count first lands on the threshold.
    if (scan_done_q) begin
      if (same_cand) begin
        if (cnt_q != DEB_MAX) cnt_d = cnt_q + 4'd1;
      end else begin
        stored_valid_d = cand_valid;
        stored_code_d  = cand_code;
        cnt_d          = 4'd1;
      end
      commit_d = (cnt_d == DEB_MAX) && (!same_cand || cnt_q != DEB_MAX);
    end

    if (commit_q) begin
      keys_d       = stored_valid_q ? stored_code_q : 4'd0;
      key_valid_d  = stored_valid_q;
      key_strobe_d = stored_valid_q && !(key_valid_q && keys_q == stored_code_q);
      rpt_d        = '0;
    end else if (REPEAT_EN && scan_done_q && key_valid_q) begin
      if (rpt_q >= RPT_LAST) begin
        rpt_d        = '0;
        key_strobe_d = 1'b1;
      end else begin
        rpt_d = rpt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      row_meta_q     <= 4'hF;
      row_sync_q     <= 4'hF;
      div_q          <= '0;
      col_q          <= 2'd0;
      snap_q         <= '0;
      scan_done_q    <= 1'b0;
      stored_valid_q <= 1'b0;
      stored_code_q  <= 4'd0;
      cnt_q          <= 4'd0;
      commit_q       <= 1'b0;
      keys_q         <= 4'd0;
      key_valid_q    <= 1'b0;
      key_strobe_q   <= 1'b0;
      rpt_q          <= 8'd0;
    end else begin
      row_meta_q     <= row_meta_d;
      row_sync_q     <= row_sync_d;
      div_q          <= div_d;
      col_q          <= col_d;
      snap_q         <= snap_d;
      scan_done_q    <= scan_done_d;
      stored_valid_q <= stored_valid_d;
      stored_code_q  <= stored_code_d;
      cnt_q          <= cnt_d;
      commit_q       <= commit_d;
      keys_q         <= keys_d;
      key_valid_q    <= key_valid_d;
      key_strobe_q   <= key_strobe_d;
      rpt_q          <= rpt_d;
    end
  end

  assign kp.col_out    = ~(4'b0001 << col_q);
  assign kp.keys       = keys_q;
  assign kp.key_valid  = key_valid_q;
  assign kp.key_strobe = key_strobe_q;
endmodule
